ap_ctrl_stats_monitor: RTL and testbench

Synthesizable, parametrised monitor for `NUM_CH` ap_ctrl_hs-style handshakes (ap_start/ap_ready/ap_done/ap_continue). It sits beside the HLS top in the cosim and FPGA harness and replaces per-module CSV sampling with on-chip statistics. For each channel it records transaction count, start-to-done latency (last/min/max), start-to-start interval, and done-stall cycles. Up to `DEPTH` overlapping transactions per channel are timed, and all statistics can be read back through a registered select port.

---
 rtl/dfmon_pkg.sv | 38 +++
 rtl/ap_chan_stats.sv | 204 ++++++++++++++++++++
 rtl/ap_ctrl_stats_monitor.sv | 82 ++++++++
 tb/tb_ap_ctrl_stats_monitor.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfmon_pkg.sv
// Shared definitions for the ap_ctrl handshake statistics monitor:
// read-select codes, channel state encoding, status-word layout and
// the saturating increment used by every statistic counter.
package dfmon_pkg;

  // Statistic selected by rd_sel
  localparam logic [2:0] SEL_TXN_COUNT     = 3'd0;
  localparam logic [2:0] SEL_LAST_LAT      = 3'd1;
  localparam logic [2:0] SEL_MIN_LAT       = 3'd2;
  localparam logic [2:0] SEL_MAX_LAT       = 3'd3;
  localparam logic [2:0] SEL_LAST_INTERVAL = 3'd4;
  localparam logic [2:0] SEL_STALL_CYCLES  = 3'd5;
  localparam logic [2:0] SEL_LOST_COUNT    = 3'd6;
  localparam logic [2:0] SEL_STATUS        = 3'd7;

  // Channel state as reported in the status word
  typedef enum logic [1:0] {
    CH_IDLE      = 2'd0,
    CH_BUSY      = 2'd1,
    CH_DONE_WAIT = 2'd2
  } ch_state_e;

  // Status word layout; occupancy sits above the flags
  localparam int ST_STATE_LSB = 0;
  localparam int ST_LOST_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_OCC_LSB   = 4;

  // Widest counter the saturating helper supports
  localparam int SAT_W = 64;

  // Increment that sticks at max_val instead of wrapping
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    return (val == max_val) ? val : val + SAT_W'(1);
  endfunction

endpackage

// File: rtl/ap_chan_stats.sv
// Statistics for one ap_ctrl_hs channel: start detection, a FIFO of
// outstanding start timestamps, latency/interval/stall/lost counters and
// a combinational select of the requested statistic.
module ap_chan_stats
  import dfmon_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] ts_i,
  input  logic             ap_start_i,
  input  logic             ap_ready_i,
  input  logic             ap_done_i,
  input  logic             ap_continue_i,
  input  logic [2:0]       rd_sel_i,
  output logic [CNT_W-1:0] sel_data_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int OW  = AW + 1;
  localparam int STW = (CNT_W > ST_OCC_LSB + OW) ? CNT_W : ST_OCC_LSB + OW;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [OW-1:0]    DEPTH_C  = OW'(DEPTH);

  logic [CNT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             pend_q, pend_d, first_q, first_d, lost_q, lost_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] prev_ts_q, prev_ts_d, txn_q, txn_d, last_lat_q, last_lat_d;
  logic [CNT_W-1:0] min_lat_q, min_lat_d, max_lat_q, max_lat_d;
  logic [CNT_W-1:0] last_int_q, last_int_d, stall_q, stall_d, lost_cnt_q, lost_cnt_d;
  ch_state_e        state_q, state_d;

  logic             start_begin, done_hs, stall, empty, full;
  logic             pop, push, bypass, timed, lost_start, empty_done;
  logic [CNT_W-1:0] lat;
  logic [STW-1:0]   status;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    logic [SAT_W-1:0] r;
    r = sat_inc(SAT_W'(v), SAT_W'(ALL_ONES));
    return r[CNT_W-1:0];
  endfunction

  assign start_begin = ap_start_i & ~pend_q;
  assign done_hs     = ap_done_i & ap_continue_i;
  assign stall       = ap_done_i & ~ap_continue_i;
  assign empty       = (occ_q == '0);
  assign full        = (occ_q == DEPTH_C);
  // A start and done together on an empty FIFO time each other directly
  assign bypass      = start_begin & done_hs & empty;
  assign pop         = done_hs & ~empty;
  assign push        = start_begin & ~bypass & (~full | pop);
  assign timed       = pop | bypass;
  assign lost_start  = start_begin & full & ~pop;
  assign empty_done  = done_hs & empty & ~start_begin;
  assign lat         = bypass ? '0 : ts_i - mem[rd_ptr_q];

  // Next-state for FIFO pointers, start tracking and all statistics
  always_comb begin
    // NOTE: every _d takes its _q value first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    pend_d     = pend_q;
    first_d    = first_q;
    prev_ts_d  = prev_ts_q;
    txn_d      = txn_q;
    last_lat_d = last_lat_q;
    min_lat_d  = min_lat_q;
    max_lat_d  = max_lat_q;
    last_int_d = last_int_q;
    stall_d    = stall_q;
    lost_cnt_d = lost_cnt_q;
    lost_d     = lost_q;
    ovf_d      = ovf_q;
    if (en_i) begin
      pend_d = ap_ready_i ? 1'b0 : (start_begin | pend_q);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      occ_d = occ_q + OW'(push) - OW'(pop);
      if (clear_i) begin
        // Clear beats any same-cycle statistic event; FIFO traffic still flows
        first_d    = 1'b1;
        txn_d      = '0;
        last_lat_d = '0;
        min_lat_d  = ALL_ONES;
        max_lat_d  = '0;
        last_int_d = '0;
        stall_d    = '0;
        lost_cnt_d = '0;
        lost_d     = 1'b0;
        ovf_d      = 1'b0;
      end else begin
        if (start_begin) begin
          if (!first_q) last_int_d = ts_i - prev_ts_q;
          first_d   = 1'b0;
          prev_ts_d = ts_i;
        end
        if (lost_start) begin
          lost_d     = 1'b1;
          lost_cnt_d = inc(lost_cnt_q);
          if (lost_cnt_q == ALL_ONES) ovf_d = 1'b1;
        end
        if (done_hs) begin
          txn_d = inc(txn_q);
          if (txn_q == ALL_ONES) ovf_d = 1'b1;
        end
        if (timed) begin
          last_lat_d = lat;
          if (lat < min_lat_q) min_lat_d = lat;
          if (lat > max_lat_q) max_lat_d = lat;
        end
        if (empty_done) lost_d = 1'b1;
        if (stall) begin
          stall_d = inc(stall_q);
          if (stall_q == ALL_ONES) ovf_d = 1'b1;
        end
      end
    end
  end

  // Channel state: a held-off done outranks outstanding work
  always_comb begin
    state_d = state_q;
    if (en_i) begin
      if (stall)              state_d = CH_DONE_WAIT;
      else if (occ_d != '0)   state_d = CH_BUSY;
      else                    state_d = CH_IDLE;
    end
  end

  // Control and statistic registers
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      pend_q     <= 1'b0;
      first_q    <= 1'b1;
      prev_ts_q  <= '0;
      txn_q      <= '0;
      last_lat_q <= '0;
      min_lat_q  <= ALL_ONES;
      max_lat_q  <= '0;
      last_int_q <= '0;
      stall_q    <= '0;
      lost_cnt_q <= '0;
      lost_q     <= 1'b0;
      ovf_q      <= 1'b0;
      state_q    <= CH_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      first_q    <= first_d;
      prev_ts_q  <= prev_ts_d;
      txn_q      <= txn_d;
      last_lat_q <= last_lat_d;
      min_lat_q  <= min_lat_d;
      max_lat_q  <= max_lat_d;
      last_int_q <= last_int_d;
      stall_q    <= stall_d;
      lost_cnt_q <= lost_cnt_d;
      lost_q     <= lost_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
    end
  end

  // Timestamp storage
  always_ff @(posedge clock) begin
    // NOTE: the FIFO array has no reset; the pointers and occupancy alone define which entries are valid.
    if (en_i && push) mem[wr_ptr_q] <= ts_i;
  end

  // Status word assembly and statistic select
  always_comb begin
    status = '0;
    status[ST_STATE_LSB +: 2]  = state_q;
    status[ST_LOST_BIT]        = lost_q;
    status[ST_OVF_BIT]         = ovf_q;
    status[ST_OCC_LSB +: OW]   = occ_q;
    sel_data_o = '0;
    case (rd_sel_i)
      SEL_TXN_COUNT:     sel_data_o = txn_q;
      SEL_LAST_LAT:      sel_data_o = last_lat_q;
      SEL_MIN_LAT:       sel_data_o = min_lat_q;
      SEL_MAX_LAT:       sel_data_o = max_lat_q;
      SEL_LAST_INTERVAL: sel_data_o = last_int_q;
      SEL_STALL_CYCLES:  sel_data_o = stall_q;
      SEL_LOST_COUNT:    sel_data_o = lost_cnt_q;
      SEL_STATUS:        sel_data_o = status[CNT_W-1:0];
      default:           sel_data_o = '0;
    endcase
  end

endmodule

// File: rtl/ap_ctrl_stats_monitor.sv
// On-chip statistics monitor for NUM_CH ap_ctrl_hs handshakes: shared
// free-running timestamp, sticky freeze, per-channel statistic blocks
// and a registered read port.
module ap_ctrl_stats_monitor
  import dfmon_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 32,
  parameter  int DEPTH  = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              finish,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              frozen
);

  logic [CNT_W-1:0] ts_q, ts_d, rd_data_q, rd_data_d;
  logic             frozen_q, frozen_d, run_en, clear_en;
  logic [CNT_W-1:0] ch_data [NUM_CH];

  assign run_en   = ~frozen_q;
  assign clear_en = clear & ~frozen_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ap_chan_stats #(
      .CNT_W (CNT_W),
      .DEPTH (DEPTH)
    ) u_chan (
      .clock         (clock),
      .reset         (reset),
      .en_i          (run_en),
      .clear_i       (clear_en),
      .ts_i          (ts_q),
      .ap_start_i    (ap_start[gi]),
      .ap_ready_i    (ap_ready[gi]),
      .ap_done_i     (ap_done[gi]),
      .ap_continue_i (ap_continue[gi]),
      .rd_sel_i      (rd_sel),
      .sel_data_o    (ch_data[gi])
    );
  end

  // Timestamp advances and freeze latches unless already frozen
  always_comb begin
    ts_d     = frozen_q ? ts_q : ts_q + CNT_W'(1);
    frozen_d = frozen_q | finish;
  end

  // Channel read mux; channels past NUM_CH read as zero
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_data_d = ch_data[i];
    end
  end

  // Timestamp, freeze flag and read-data registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q      <= '0;
      frozen_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ts_q      <= ts_d;
      frozen_q  <= frozen_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign frozen  = frozen_q;

endmodule

// File: tb/tb_ap_ctrl_stats_monitor.sv
// Self-checking bench: a 4-channel 32-bit monitor for the functional
// scenarios and a 1-channel 4-bit monitor for counter saturation.
module tb_ap_ctrl_stats_monitor;

  typedef struct {
    bit          dut;
    logic [1:0]  ch;
    logic [2:0]  sel;
    logic [31:0] exp;
    string       name;
  } rvec_t;

  typedef struct {
    bit          dut;
    logic [31:0] exp;
    string       name;
  } sb_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        finish = 1'b0;
  logic [3:0]  ap_start = '0, ap_ready = '0, ap_done = '0, ap_continue = 4'hF;
  logic [1:0]  rd_ch = '0;
  logic [2:0]  rd_sel = '0;
  logic [31:0] rd_data;
  logic        frozen;

  logic        s_start = 1'b0, s_ready = 1'b0, s_done = 1'b0, s_cont = 1'b1;
  logic [0:0]  s_rd_ch = '0;
  logic [2:0]  s_rd_sel = '0;
  logic [3:0]  s_rd_data;
  logic        s_frozen;

  rvec_t tbl[$];
  sb_t   sb_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    ts_m = 0;
  bit    frz_m = 1'b0;

  always #5 clock = ~clock;

  ap_ctrl_stats_monitor #(.NUM_CH(4), .CNT_W(32), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .clear(clear), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data), .frozen(frozen)
  );

  ap_ctrl_stats_monitor #(.NUM_CH(1), .CNT_W(4), .DEPTH(2)) dut_sat (
    .clock(clock), .reset(reset), .clear(1'b0), .finish(1'b0),
    .ap_start(s_start), .ap_ready(s_ready), .ap_done(s_done),
    .ap_continue(s_cont), .rd_ch(s_rd_ch), .rd_sel(s_rd_sel),
    .rd_data(s_rd_data), .frozen(s_frozen)
  );

  // Reference timestamp: counts edges since reset, stops once finish is seen
  always @(posedge clock) begin
    if (reset) begin
      ts_m  <= 0;
      frz_m <= 1'b0;
    end else begin
      if (!frz_m) ts_m <= ts_m + 1;
      if (finish) frz_m <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wait_ts(input int t);
    int guard;
    guard = 0;
    while (ts_m < t && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    if (ts_m != t) check("wait_ts", ts_m, t);
  endtask

  task automatic add(input bit d, input logic [1:0] ch, input logic [2:0] sel,
                     input logic [31:0] exp, input string name);
    tbl.push_back('{d, ch, sel, exp, name});
  endtask

  // Drive each read, queue its expectation, compare one cycle later
  task automatic run_tbl();
    sb_t         e;
    logic [31:0] act;
    for (int i = 0; i < tbl.size(); i++) begin
      rd_ch    = tbl[i].ch;
      rd_sel   = tbl[i].sel;
      s_rd_sel = tbl[i].sel;
      sb_q.push_back('{tbl[i].dut, tbl[i].exp, tbl[i].name});
      @(negedge clock);
      e   = sb_q.pop_front();
      act = e.dut ? {28'd0, s_rd_data} : rd_data;
      check(e.name, act, e.exp);
    end
    tbl.delete();
  endtask

  task automatic start_pulse(input logic [1:0] ch, input bit with_done);
    ap_start[ch] = 1'b1;
    ap_ready[ch] = 1'b1;
    if (with_done) ap_done[ch] = 1'b1;
    step();
    ap_start[ch] = 1'b0;
    ap_ready[ch] = 1'b0;
    ap_done[ch]  = 1'b0;
  endtask

  task automatic done_pulse(input logic [1:0] ch);
    ap_done[ch] = 1'b1;
    step();
    ap_done[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    add(1'b0, 2'd0, 3'd0, 32'd0,          "rst_txn");
    add(1'b0, 2'd0, 3'd2, 32'hFFFF_FFFF,  "rst_min_lat");
    add(1'b0, 2'd0, 3'd7, 32'd0,          "rst_status");
    add(1'b0, 2'd3, 3'd5, 32'd0,          "rst_stall");
    run_tbl();
    check("rst_frozen", {31'd0, frozen}, 32'd0);

    // Single transaction on ch0: start 10, ready 12, done 25
    wait_ts(10); ap_start[0] = 1'b1;
    wait_ts(12); ap_ready[0] = 1'b1;
    step();      ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    wait_ts(15);
    add(1'b0, 2'd0, 3'd7, 32'h11, "t1_status_busy"); run_tbl();
    wait_ts(25); done_pulse(2'd0);
    add(1'b0, 2'd0, 3'd0, 32'd1,  "t1_txn");
    add(1'b0, 2'd0, 3'd1, 32'd15, "t1_last_lat");
    add(1'b0, 2'd0, 3'd2, 32'd15, "t1_min_lat");
    add(1'b0, 2'd0, 3'd3, 32'd15, "t1_max_lat");
    add(1'b0, 2'd0, 3'd4, 32'd0,  "t1_interval");
    add(1'b0, 2'd0, 3'd7, 32'd0,  "t1_status_idle");
    run_tbl();

    // Overlapped starts on ch1: 45, 49, 53; dones 60, 64, 70
    wait_ts(45); start_pulse(2'd1, 1'b0);
    wait_ts(49); start_pulse(2'd1, 1'b0);
    wait_ts(53); start_pulse(2'd1, 1'b0);
    wait_ts(55);
    add(1'b0, 2'd1, 3'd7, 32'h31, "ovl_occ3"); run_tbl();
    wait_ts(60); done_pulse(2'd1);
    wait_ts(64); done_pulse(2'd1);
    wait_ts(70); done_pulse(2'd1);
    add(1'b0, 2'd1, 3'd0, 32'd3,  "ovl_txn");
    add(1'b0, 2'd1, 3'd1, 32'd17, "ovl_last_lat");
    add(1'b0, 2'd1, 3'd2, 32'd15, "ovl_min_lat");
    add(1'b0, 2'd1, 3'd3, 32'd17, "ovl_max_lat");
    add(1'b0, 2'd1, 3'd4, 32'd4,  "ovl_interval");
    add(1'b0, 2'd1, 3'd7, 32'd0,  "ovl_status");
    run_tbl();

    // FIFO overflow on ch2: five starts, then five dones
    for (int k = 0; k < 5; k++) begin
      wait_ts(80 + 2 * k);
      start_pulse(2'd2, 1'b0);
    end
    wait_ts(90);
    add(1'b0, 2'd2, 3'd6, 32'd1,  "ovf_lost_count");
    add(1'b0, 2'd2, 3'd7, 32'h45, "ovf_status_full");
    run_tbl();
    for (int k = 0; k < 5; k++) begin
      wait_ts(100 + 2 * k);
      done_pulse(2'd2);
    end
    add(1'b0, 2'd2, 3'd0, 32'd5,  "ovf_txn");
    add(1'b0, 2'd2, 3'd1, 32'd20, "ovf_last_lat");
    add(1'b0, 2'd2, 3'd2, 32'd20, "ovf_min_lat");
    add(1'b0, 2'd2, 3'd3, 32'd20, "ovf_max_lat");
    add(1'b0, 2'd2, 3'd6, 32'd1,  "ovf_lost_after");
    add(1'b0, 2'd2, 3'd4, 32'd2,  "ovf_interval");
    add(1'b0, 2'd2, 3'd7, 32'h04, "ovf_status_lost");
    run_tbl();

    // Done stall on ch3: start 120, done held off 125..131, accepted 132
    wait_ts(120); start_pulse(2'd3, 1'b0);
    wait_ts(125); ap_done[3] = 1'b1; ap_continue[3] = 1'b0;
    wait_ts(128);
    add(1'b0, 2'd3, 3'd7, 32'h12, "stall_status_dw"); run_tbl();
    wait_ts(132); ap_continue[3] = 1'b1;
    step();       ap_done[3] = 1'b0;
    add(1'b0, 2'd3, 3'd5, 32'd7,  "stall_cycles");
    add(1'b0, 2'd3, 3'd0, 32'd1,  "stall_txn");
    add(1'b0, 2'd3, 3'd1, 32'd12, "stall_last_lat");
    run_tbl();

    // Clear coinciding with a done on ch3
    wait_ts(140); start_pulse(2'd3, 1'b0);
    wait_ts(143); ap_done[3] = 1'b1; clear = 1'b1;
    step();       ap_done[3] = 1'b0; clear = 1'b0;
    add(1'b0, 2'd3, 3'd0, 32'd0,         "clr_txn");
    add(1'b0, 2'd3, 3'd2, 32'hFFFF_FFFF, "clr_min_lat");
    add(1'b0, 2'd3, 3'd1, 32'd0,         "clr_last_lat");
    add(1'b0, 2'd3, 3'd5, 32'd0,         "clr_stall");
    add(1'b0, 2'd0, 3'd0, 32'd0,         "clr_ch0_txn");
    add(1'b0, 2'd2, 3'd6, 32'd0,         "clr_ch2_lost_count");
    add(1'b0, 2'd2, 3'd7, 32'd0,         "clr_ch2_status");
    run_tbl();

    // Same-cycle start/done: empty FIFO at 160, one outstanding at 176
    wait_ts(160); start_pulse(2'd0, 1'b1);
    wait_ts(170); start_pulse(2'd0, 1'b0);
    wait_ts(176); start_pulse(2'd0, 1'b1);
    wait_ts(180); done_pulse(2'd0);
    add(1'b0, 2'd0, 3'd0, 32'd3, "sc_txn");
    add(1'b0, 2'd0, 3'd1, 32'd4, "sc_last_lat");
    add(1'b0, 2'd0, 3'd2, 32'd0, "sc_min_lat");
    add(1'b0, 2'd0, 3'd3, 32'd6, "sc_max_lat");
    add(1'b0, 2'd0, 3'd4, 32'd6, "sc_interval");
    add(1'b0, 2'd0, 3'd7, 32'd0, "sc_status");
    run_tbl();

    // Saturation on the 4-bit monitor: 16 stall cycles
    wait_ts(190); s_done = 1'b1; s_cont = 1'b0;
    wait_ts(206); s_done = 1'b0; s_cont = 1'b1;
    add(1'b1, 2'd0, 3'd5, 32'd15, "sat_stall");
    add(1'b1, 2'd0, 3'd7, 32'h8,  "sat_status_ovf");
    add(1'b1, 2'd0, 3'd0, 32'd0,  "sat_txn");
    run_tbl();
    check("sat_frozen", {31'd0, s_frozen}, 32'd0);

    // Freeze, then traffic and clear must leave everything untouched
    finish = 1'b1;
    step();
    finish = 1'b0;
    check("frz_set", {31'd0, frozen}, 32'd1);
    start_pulse(2'd0, 1'b0);
    step();
    ap_done[0] = 1'b1; ap_continue[0] = 1'b0;
    step(); step();
    ap_continue[0] = 1'b1;
    step();
    ap_done[0] = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    add(1'b0, 2'd0, 3'd0, 32'd3, "frz_txn");
    add(1'b0, 2'd0, 3'd1, 32'd4, "frz_last_lat");
    add(1'b0, 2'd0, 3'd3, 32'd6, "frz_max_lat");
    add(1'b0, 2'd0, 3'd5, 32'd0, "frz_stall");
    add(1'b0, 2'd0, 3'd4, 32'd6, "frz_interval");
    add(1'b0, 2'd0, 3'd7, 32'd0, "frz_status");
    run_tbl();
    check("frz_still", {31'd0, frozen}, 32'd1);

    // Reset clears the freeze and all statistics
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("rst2_frozen", {31'd0, frozen}, 32'd0);
    add(1'b0, 2'd0, 3'd0, 32'd0,         "rst2_txn");
    add(1'b0, 2'd0, 3'd1, 32'd0,         "rst2_last_lat");
    add(1'b0, 2'd0, 3'd2, 32'hFFFF_FFFF, "rst2_min_lat");
    add(1'b0, 2'd0, 3'd3, 32'd0,         "rst2_max_lat");
    add(1'b0, 2'd0, 3'd4, 32'd0,         "rst2_interval");
    run_tbl();

    // Reset mid-transaction: the later done finds an empty FIFO
    start_pulse(2'd2, 1'b0);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    done_pulse(2'd2);
    add(1'b0, 2'd2, 3'd0, 32'd1,         "rmid_txn");
    add(1'b0, 2'd2, 3'd1, 32'd0,         "rmid_last_lat");
    add(1'b0, 2'd2, 3'd2, 32'hFFFF_FFFF, "rmid_min_lat");
    add(1'b0, 2'd2, 3'd7, 32'h04,        "rmid_status_lost");
    run_tbl();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
